// File: rtl/sipo_frame_if.sv
// sipo_frame_if: serial source and parallel consumer signals of the SIPO frame controller
interface sipo_frame_if #(
  parameter int WIDTH = 4,
  parameter int CW = $clog2(WIDTH + 1)
);
  logic             start;
  logic             din;
  logic             din_en;
  logic             dout_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  modport master (
    output start, din, din_en, dout_ready, clr_ovr,
    input  dout, dout_valid, busy, bit_cnt, overrun
  );
  modport slave (
    input  start, din, din_en, dout_ready, clr_ovr,
    output dout, dout_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames a strobed serial stream into WIDTH-bit words behind a valid/ready holding register
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input logic         CLK,
  input logic         RST,
  sipo_frame_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d, ovr_q, ovr_d;
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q & ~bus.dout_ready;
    ovr_d   = ovr_q & ~bus.clr_ovr;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
    end else if (bus.start) begin
      cnt_d = '0;
    end else if (bus.din_en) begin
      sreg_d = {sreg_q[WIDTH-2:0], bus.din};
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        // a full holding register that is not being drained drops the new word
        if (!valid_q || bus.dout_ready) begin
          dout_d  = sreg_d;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed checks of framing, gaps, restart, overrun and reset
module tb_sipo_frame_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad = 0;
  sipo_frame_if #(.WIDTH(4)) bus ();
  sipo_frame_ctrl #(.WIDTH(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic d);
    bus.din    = d;
    bus.din_en = 1'b1;
    tick();
    bus.din_en = 1'b0;
  endtask
  task automatic frame(input logic [3:0] w, input logic rdy_last, input logic clr_last);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 3; i > 0; i--) send(w[i]);
    bus.dout_ready = rdy_last;
    bus.clr_ovr    = clr_last;
    send(w[0]);
    bus.dout_ready = 1'b0;
    bus.clr_ovr    = 1'b0;
  endtask
  task automatic accept;
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.din = 0; bus.din_en = 0; bus.dout_ready = 0; bus.clr_ovr = 0;
    tick();
    tick();
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.bit_cnt, 0);
    chk("rst_ovr", bus.overrun, 0);
    RST = 1'b0;
    send(1'b1);
    chk("idle_ignore_en", bus.bit_cnt, 0);
    bus.start = 1'b1; bus.din_en = 1'b1; bus.din = 1'b0;
    tick();
    bus.start = 1'b0; bus.din_en = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_cnt", bus.bit_cnt, 0);
    send(1'b1);
    send(1'b0);
    chk("mid_cnt", bus.bit_cnt, 2);
    send(1'b1);
    chk("pre_final_valid", bus.dout_valid, 0);
    send(1'b1);
    chk("f1_dout", bus.dout, 4'b1011);
    chk("f1_valid", bus.dout_valid, 1);
    chk("f1_busy", bus.busy, 0);
    chk("f1_cnt", bus.bit_cnt, 0);
    tick();
    chk("hold_dout", bus.dout, 4'b1011);
    accept();
    chk("acc_valid", bus.dout_valid, 0);
    chk("acc_dout", bus.dout, 4'b1011);
    accept();
    chk("ready_idle_noeffect", bus.dout_valid, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    begin
      logic [3:0] g = 4'b0110;
      for (int i = 3; i >= 0; i--) begin
        send(g[i]);
        if (i > 0) begin
          repeat (3) tick();
          chk("gap_cnt", bus.bit_cnt, 4 - i);
          chk("gap_novalid", bus.dout_valid, 0);
        end
      end
    end
    chk("gap_dout", bus.dout, 4'b0110);
    chk("gap_valid", bus.dout_valid, 1);
    accept();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send(1'b1);
    send(1'b1);
    bus.start = 1'b1; bus.din_en = 1'b1; bus.din = 1'b1;
    tick();
    bus.start = 1'b0; bus.din_en = 1'b0;
    chk("restart_cnt", bus.bit_cnt, 0);
    chk("restart_busy", bus.busy, 1);
    send(1'b0);
    send(1'b0);
    send(1'b0);
    chk("restart_novalid", bus.dout_valid, 0);
    send(1'b1);
    chk("restart_dout", bus.dout, 4'b0001);
    chk("restart_valid", bus.dout_valid, 1);
    accept();
    frame(4'b1010, 1'b0, 1'b0);
    chk("ovrA_dout", bus.dout, 4'b1010);
    chk("ovrA_ovr", bus.overrun, 0);
    frame(4'b0101, 1'b0, 1'b0);
    chk("ovrB_dout", bus.dout, 4'b1010);
    chk("ovrB_valid", bus.dout_valid, 1);
    chk("ovrB_ovr", bus.overrun, 1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    chk("clr_ovr", bus.overrun, 0);
    frame(4'b0111, 1'b0, 1'b1);
    chk("set_wins_ovr", bus.overrun, 1);
    chk("set_wins_dout", bus.dout, 4'b1010);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    chk("clr_ovr2", bus.overrun, 0);
    frame(4'b0101, 1'b1, 1'b0);
    chk("simul_dout", bus.dout, 4'b0101);
    chk("simul_valid", bus.dout_valid, 1);
    chk("simul_ovr", bus.overrun, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send(1'b1);
    send(1'b1);
    RST = 1'b1;
    bus.din_en = 1'b1;
    tick();
    bus.din_en = 1'b0;
    RST = 1'b0;
    chk("mrst_dout", bus.dout, 0);
    chk("mrst_valid", bus.dout_valid, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_cnt", bus.bit_cnt, 0);
    send(1'b1);
    chk("mrst_idle", bus.busy, 0);
    frame(4'b1100, 1'b0, 1'b0);
    chk("post_dout", bus.dout, 4'b1100);
    chk("post_valid", bus.dout_valid, 1);
    chk("post_ovr", bus.overrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
